// File: rtl/an_barrett_decoder_seq.sv
// an_barrett_decoder_seq
// Streaming AN-code decoder. A four-stage Barrett pipeline computes the
// quotient q and the residue r = x mod A. A residue of zero returns q directly.
// A nonzero residue hands the word to a search FSM. The FSM walks the bit
// indices one per cycle, looking for a single arithmetic error of +/-2^i.
// A channel tag rides along with every word, so one instance can be shared
// by many channels.
module an_barrett_decoder_seq #(
    parameter int A  = 37,
    parameter int CW = 18,
    parameter int DW = 13,
    parameter int K  = 18,
    parameter int TW = 6,
    parameter int RW = $clog2(A),   // derived: residue width
    parameter int IW = $clog2(CW)   // derived: bit index width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_code,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [TW-1:0] out_tag,
    output logic          out_err,
    output logic          out_corr,
    output logic          out_fail,
    output logic [RW-1:0] out_syn,
    output logic [IW-1:0] out_pos,
    output logic          out_neg
);

    // Residue table: P_i = 2^i mod A.
    function automatic logic [CW*RW-1:0] build_p_tab();
        logic [CW*RW-1:0] t;
        longint           v;
        t = {(CW*RW){1'b0}};
        for (int i = 0; i < CW; i++) begin
            v = (64'sd1 <<< i) % longint'(A);
            t[i*RW +: RW] = v[RW-1:0];
        end
        return t;
    endfunction

    // Quotient table: Q_i = floor(2^i / A).
    function automatic logic [CW*DW-1:0] build_q_tab();
        logic [CW*DW-1:0] t;
        longint           v;
        t = {(CW*DW){1'b0}};
        for (int i = 0; i < CW; i++) begin
            v = (64'sd1 <<< i) / longint'(A);
            t[i*DW +: DW] = v[DW-1:0];
        end
        return t;
    endfunction

    localparam int               PW       = CW + K;
    // The raw residue x - q*A stays below 2A, so two extra bits are enough.
    localparam int               EW       = RW + 2;
    localparam longint           M_L      = (64'sd1 <<< K) / longint'(A);
    localparam logic [K-1:0]     M_V      = M_L[K-1:0];
    localparam logic [EW-1:0]    A_E      = EW'(A);
    localparam logic [RW-1:0]    A_R      = RW'(A);
    localparam logic [CW*RW-1:0] P_TAB    = build_p_tab();
    localparam logic [CW*DW-1:0] Q_TAB    = build_q_tab();
    localparam logic [IW-1:0]    IDX_LAST = IW'(CW - 1);
    localparam logic [IW-1:0]    IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    // Pipeline registers
    logic          s1_valid_r, s2_valid_r, s3_valid_r, s4_valid_r;
    logic [CW-1:0] s1_x_r, s2_x_r, s3_x_r, s4_x_r;
    logic [TW-1:0] s1_tag_r, s2_tag_r, s3_tag_r, s4_tag_r;
    logic [PW-1:0] s2_p_r;
    logic [DW-1:0] s3_q_r, s4_q_r;
    logic [EW-1:0] s3_r0_r;
    logic [RW-1:0] s4_r_r;

    // Pipeline combinational values
    logic [PW-1:0] s1_prod_s;
    logic [CW-1:0] s3_qfull_s;
    logic [DW-1:0] s3_q_s;
    logic [EW-1:0] s3_r0_s;
    logic          s4_ge1_s, s4_ge2_s;
    logic [EW-1:0] s4_ra_s, s4_rb_s;
    logic [1:0]    s4_cnt_s;
    logic [DW-1:0] s4_q_s;
    logic [RW-1:0] s4_r_s;

    // Search FSM state and the word it is working on
    state_t        state_r, state_n_s;
    logic [IW-1:0] idx_r, idx_n_s;
    logic [CW-1:0] f_x_r;
    logic [DW-1:0] f_q_r;
    logic [RW-1:0] f_r_r;
    logic [TW-1:0] f_tag_r;

    // Search and output-load combinational values
    logic [RW-1:0] s_p_s;
    logic [DW-1:0] s_q_s;
    logic [CW:0]   pow_s, neg_sum_s;
    logic          pos_hit_s, neg_hit_s;
    logic          load_ok_s, adv_s, latch_s, load_s;
    logic [DW-1:0] ld_data_s;
    logic [TW-1:0] ld_tag_s;
    logic          ld_err_s, ld_corr_s, ld_fail_s, ld_neg_s;
    logic [RW-1:0] ld_syn_s;
    logic [IW-1:0] ld_pos_s;
    logic          unused_bits_s;

    // The output slot is free when it is empty or is being accepted this cycle.
    assign load_ok_s = !out_valid || out_ready;
    assign adv_s     = (state_r == ST_IDLE) && load_ok_s;
    assign in_ready  = adv_s;

    // The low product bits and the high quotient bits never affect the result.
    assign unused_bits_s = ^{s2_p_r[K-1:0], s3_qfull_s[CW-1:DW], s4_rb_s[EW-1:RW]};

    // Barrett arithmetic between pipeline registers
    always_comb begin
        s1_prod_s  = {{K{1'b0}}, s1_x_r} * {{CW{1'b0}}, M_V};
        s3_qfull_s = s2_p_r[PW-1:K];
        s3_q_s     = s3_qfull_s[DW-1:0];
        // Only the low EW bits matter: the true difference is below 2A.
        s3_r0_s    = s2_x_r[EW-1:0] - s3_qfull_s[EW-1:0] * A_E;
        s4_ge1_s   = (s3_r0_r >= A_E);
        s4_ra_s    = s4_ge1_s ? (s3_r0_r - A_E) : s3_r0_r;
        s4_ge2_s   = (s4_ra_s >= A_E);
        s4_rb_s    = s4_ge2_s ? (s4_ra_s - A_E) : s4_ra_s;
        s4_cnt_s   = {1'b0, s4_ge1_s} + {1'b0, s4_ge2_s};
        s4_q_s     = s3_q_r + {{(DW-2){1'b0}}, s4_cnt_s};
        s4_r_s     = s4_rb_s[RW-1:0];
    end

    // Pipeline stages S1..S4, all advancing together on adv
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;            s4_valid_r <= 1'b0;
            s1_x_r     <= {CW{1'b0}};      s2_x_r     <= {CW{1'b0}};
            s3_x_r     <= {CW{1'b0}};      s4_x_r     <= {CW{1'b0}};
            s1_tag_r   <= {TW{1'b0}};      s2_tag_r   <= {TW{1'b0}};
            s3_tag_r   <= {TW{1'b0}};      s4_tag_r   <= {TW{1'b0}};
            s2_p_r     <= {PW{1'b0}};
            s3_q_r     <= {DW{1'b0}};      s4_q_r     <= {DW{1'b0}};
            s3_r0_r    <= {EW{1'b0}};      s4_r_r     <= {RW{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= in_valid;        s1_x_r     <= in_code;
            s1_tag_r   <= in_tag;
            s2_valid_r <= s1_valid_r;      s2_x_r     <= s1_x_r;
            s2_tag_r   <= s1_tag_r;        s2_p_r     <= s1_prod_s;
            s3_valid_r <= s2_valid_r;      s3_x_r     <= s2_x_r;
            s3_tag_r   <= s2_tag_r;        s3_q_r     <= s3_q_s;
            s3_r0_r    <= s3_r0_s;
            s4_valid_r <= s3_valid_r;      s4_x_r     <= s3_x_r;
            s4_tag_r   <= s3_tag_r;        s4_q_r     <= s4_q_s;
            s4_r_r     <= s4_r_s;
        end
    end

    // Candidate match for the current search index
    always_comb begin
        s_p_s     = P_TAB[int'(idx_r)*RW +: RW];
        s_q_s     = Q_TAB[int'(idx_r)*DW +: DW];
        pow_s     = {{CW{1'b0}}, 1'b1} << idx_r;
        neg_sum_s = {1'b0, f_x_r} + pow_s;
        // +2^i error: the word must have been at least 2^i before the error.
        pos_hit_s = (f_r_r == s_p_s) && ({1'b0, f_x_r} >= pow_s);
        // -2^i error: the original word x + 2^i must fit in CW bits.
        neg_hit_s = (f_r_r == (A_R - s_p_s)) && !neg_sum_s[CW];
    end

    // Search FSM next state and output-load selection
    always_comb begin
        state_n_s = state_r;
        idx_n_s   = idx_r;
        latch_s   = 1'b0;
        load_s    = 1'b0;
        ld_data_s = {DW{1'b0}};
        ld_tag_s  = {TW{1'b0}};
        ld_err_s  = 1'b0;
        ld_corr_s = 1'b0;
        ld_fail_s = 1'b0;
        ld_syn_s  = {RW{1'b0}};
        ld_pos_s  = {IW{1'b0}};
        ld_neg_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (adv_s && s4_valid_r) begin
                    if (s4_r_r == {RW{1'b0}}) begin
                        load_s    = 1'b1;
                        ld_data_s = s4_q_r;
                        ld_tag_s  = s4_tag_r;
                    end else begin
                        latch_s   = 1'b1;
                        state_n_s = ST_SEARCH;
                        idx_n_s   = {IW{1'b0}};
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                ld_tag_s = f_tag_r;
                ld_err_s = 1'b1;
                ld_syn_s = f_r_r;
                if (pos_hit_s) begin
                    ld_data_s = f_q_r - s_q_s;
                    ld_corr_s = 1'b1;
                    ld_pos_s  = idx_r;
                end else if (neg_hit_s) begin
                    ld_data_s = f_q_r + s_q_s + {{(DW-1){1'b0}}, 1'b1};
                    ld_corr_s = 1'b1;
                    ld_pos_s  = idx_r;
                    ld_neg_s  = 1'b1;
                end else begin
                    ld_data_s = f_q_r;
                    ld_fail_s = 1'b1;
                end
                if (pos_hit_s || neg_hit_s || (idx_r == IDX_LAST)) begin
                    // Hold the current index until the output slot frees up.
                    if (load_ok_s) begin
                        load_s    = 1'b1;
                        state_n_s = ST_IDLE;
                        idx_n_s   = {IW{1'b0}};
                    end else begin
                        state_n_s = ST_SEARCH;
                    end
                end else begin
                    idx_n_s = idx_r + IDX_ONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                idx_n_s   = {IW{1'b0}};
            end
        endcase
    end

    // Search FSM state, index and latched word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            f_x_r   <= {CW{1'b0}};
            f_q_r   <= {DW{1'b0}};
            f_r_r   <= {RW{1'b0}};
            f_tag_r <= {TW{1'b0}};
        end else begin
            state_r <= state_n_s;
            idx_r   <= idx_n_s;
            if (latch_s) begin
                f_x_r   <= s4_x_r;
                f_q_r   <= s4_q_r;
                f_r_r   <= s4_r_r;
                f_tag_r <= s4_tag_r;
            end
        end
    end

    // Output register: load a new result, or drop valid once it is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {DW{1'b0}};
            out_tag   <= {TW{1'b0}};
            out_err   <= 1'b0;
            out_corr  <= 1'b0;
            out_fail  <= 1'b0;
            out_syn   <= {RW{1'b0}};
            out_pos   <= {IW{1'b0}};
            out_neg   <= 1'b0;
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_data  <= ld_data_s;
            out_tag   <= ld_tag_s;
            out_err   <= ld_err_s;
            out_corr  <= ld_corr_s;
            out_fail  <= ld_fail_s;
            out_syn   <= ld_syn_s;
            out_pos   <= ld_pos_s;
            out_neg   <= ld_neg_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_an_barrett_decoder_seq.sv
// Testbench for an_barrett_decoder_seq. A reference model decodes each
// accepted word with plain division and modulo arithmetic. A monitor compares
// every delivered result, in order, against that model.
module tb_an_barrett_decoder_seq;

    localparam int A  = 37;
    localparam int CW = 18;
    localparam int DW = 13;
    localparam int TW = 6;
    localparam int RW = 6;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_code;
    logic [TW-1:0] in_tag, out_tag;
    logic [DW-1:0] out_data;
    logic          out_err, out_corr, out_fail, out_neg;
    logic [RW-1:0] out_syn;
    logic [IW-1:0] out_pos;

    an_barrett_decoder_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_err(out_err), .out_corr(out_corr), .out_fail(out_fail),
        .out_syn(out_syn), .out_pos(out_pos), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err, corr, fail, neg;
        logic [RW-1:0] syn;
        logic [IW-1:0] pos;
        int            acc;
        int            lat;
        bit            chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   lat_mode    = 1'b0;
    bit   sends_done  = 1'b0;
    bit   held        = 1'b0;
    logic [63:0] snap = 64'd0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
        end
    endtask

    // Reference decode: exact residue and quotient, then a search over +/-2^i.
    function automatic exp_t model(input int x, input int t);
        exp_t e;
        int   r, p;
        bit   found;
        r = x % A;
        e.tag = TW'(t); e.syn = RW'(r); e.err = (r != 0);
        e.corr = 1'b0; e.fail = 1'b0; e.neg = 1'b0; e.pos = '0;
        e.acc = 0; e.chk_lat = lat_mode;
        e.data = DW'(x / A); e.lat = 4;
        if (r != 0) begin
            found = 1'b0;
            for (int i = 0; i < CW; i++) begin
                p = 32'sd1 <<< i;
                if (!found && (p % A) == r && x >= p) begin
                    found = 1'b1; e.data = DW'((x - p) / A); e.corr = 1'b1;
                    e.pos = IW'(i); e.lat = 5 + i;
                end else if (!found && (A - p % A) == r && (x + p) < (32'sd1 <<< CW)) begin
                    found = 1'b1; e.data = DW'((x + p) / A); e.corr = 1'b1;
                    e.pos = IW'(i); e.neg = 1'b1; e.lat = 5 + i;
                end
            end
            if (!found) begin
                e.fail = 1'b1; e.data = DW'(x / A); e.lat = 4 + CW;
            end
        end
        return e;
    endfunction

    function automatic logic [CW-1:0] rand_code();
        int n, i, v, kind;
        n = int'($urandom_range(0, 7084));
        i = int'($urandom_range(0, CW - 1));
        kind = int'($urandom_range(0, 2));
        v = n * A;
        if (kind == 1) v = v + (32'sd1 <<< i);
        if (kind == 2) v = v - (32'sd1 <<< i);
        if (v < 0 || v >= (32'sd1 <<< CW)) v = n * A;
        return CW'(v);
    endfunction

    function automatic logic [63:0] fields();
        return 64'({out_data, out_tag, out_err, out_corr, out_fail, out_syn, out_pos, out_neg});
    endfunction

    // Monitor: scoreboard pops on output transfers, pushes on input transfers,
    // and checks that a stalled output keeps all its fields.
    always @(negedge clk) begin
        automatic exp_t e;
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_fields", fields(), snap);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 64'(out_data), 64'(e.data));
                    chk("tag",  64'(out_tag),  64'(e.tag));
                    chk("err",  64'(out_err),  64'(e.err));
                    chk("corr", 64'(out_corr), 64'(e.corr));
                    chk("fail", 64'(out_fail), 64'(e.fail));
                    chk("syn",  64'(out_syn),  64'(e.syn));
                    chk("pos",  64'(out_pos),  64'(e.pos));
                    chk("neg",  64'(out_neg),  64'(e.neg));
                    if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (in_valid && in_ready) begin
                e = model(int'(in_code), int'(in_tag));
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
            held <= out_valid && !out_ready;
            snap <= fields();
        end
    end

    task automatic send(input logic [CW-1:0] x, input logic [TW-1:0] t);
        int n;
        in_valid = 1'b1; in_code = x; in_tag = t;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_code = '0; in_tag = '0; out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fields", fields(), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Clean sweep, back to back, with latency checks
        lat_mode = 1'b1;
        for (int k = 0; k < 24; k++) send(CW'(37 * k), TW'(k));
        wait_drain();

        // Directed error cases: +2^2, -2^3, and a range-limited failure
        send(18'd189, 6'd1);    wait_drain();
        send(18'd177, 6'd2);    wait_drain();
        send(18'd262143, 6'd3); wait_drain();

        // Isolated random words, each with a latency check
        for (int k = 0; k < 20; k++) begin
            send(rand_code(), TW'($urandom_range(0, 63)));
            wait_drain();
        end

        // Backpressure over a mixed stream with tags 0..35
        lat_mode = 1'b0;
        sends_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 36; k++) send((k == 0) ? 18'd0 : rand_code(), TW'(k));
                sends_done = 1'b1;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(negedge clk);
                chk("in_ready_full", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                for (int n = 0; n < 2000 && !sends_done; n++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while the search FSM is busy on x = 189
        lat_mode = 1'b1;
        send(18'd189, 6'd5);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_fields", fields(), 64'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send(18'd74, 6'd6);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
